data_plane_rx_ctrl: RTL and testbench



---
 rtl/dp_rx_pkg.sv | 11 +
 rtl/dp_stack_ptr.sv | 53 +++++
 rtl/data_plane_rx_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_data_plane_rx_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_rx_pkg.sv
// Shared types and packet field layout for the data-plane receive controller.
package dp_rx_pkg;

   typedef enum logic {IDLE, RECV} rx_state_e;

   localparam int unsigned DEST_HI       = 31;
   localparam int unsigned DEST_LO       = 16;
   localparam int unsigned DATA_W        = 16;
   localparam int unsigned BURST_LEN_DEF = 5;

endpackage

// File: rtl/dp_stack_ptr.sv
// Receive stack pointer: next-free-slot pointer plus burst base for rollback.
module dp_stack_ptr #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic            i_rollback,
   input  logic            i_mark,
   output logic [ADDR_W:0] o_sp,
   output logic            o_full,
   output logic            o_empty
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] r_sp;
   logic [ADDR_W:0] r_base;
   logic [ADDR_W:0] w_sp_next;
   logic [ADDR_W:0] w_base_next;

   always_comb begin
      w_sp_next   = r_sp;
      w_base_next = r_base;
      if (i_mark) begin
         w_base_next = r_sp;
      end
      // Rollback restores the pointer captured when the burst began.
      if (i_rollback) begin
         w_sp_next = r_base;
      end else if (i_push) begin
         w_sp_next = r_sp + 1'b1;
      end else if (i_pop) begin
         w_sp_next = r_sp - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp   <= '0;
         r_base <= '0;
      end else begin
         r_sp   <= w_sp_next;
         r_base <= w_base_next;
      end
   end

   assign o_sp    = r_sp;
   assign o_full  = (r_sp == DEPTH);
   assign o_empty = (r_sp == '0);

endmodule

// File: rtl/data_plane_rx_ctrl.sv
// Receive-side stack RAM sequencer: frames addressed bursts, arbitrates the
// single RAM port between burst writes and GPP pops, and reports status.
module data_plane_rx_ctrl
   import dp_rx_pkg::*;
#(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned BURST_LEN = BURST_LEN_DEF,
   parameter int unsigned ID_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       rx_packet,
   input  logic [ID_W-1:0]   node_id,
   input  logic              gpp_pop,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   output logic              pop_valid,
   output logic              rx_complete,
   output logic              rx_abort,
   output logic [ADDR_W:0]   stack_count,
   output logic              stack_empty,
   output logic              stack_full,
   output logic              overflow_err
);

   localparam int unsigned          BEAT_W    = $clog2(BURST_LEN + 1);
   localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN);
   localparam logic [BEAT_W-1:0]    ONE_BEAT  = BEAT_W'(1);

   rx_state_e r_state;
   rx_state_e w_state_next;

   logic [BEAT_W-1:0] r_beat;
   logic [BEAT_W-1:0] w_beat_next;
   logic [BEAT_W-1:0] w_beat_inc;

   logic              r_pop_pending;
   logic              r_pop_s1;
   logic              r_pop_s2;
   logic              r_pop_valid;
   logic              r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [15:0]       r_ram_wdata;
   logic              r_rx_complete;
   logic              r_rx_abort;
   logic              r_overflow;

   logic              w_match;
   logic              w_write;
   logic              w_mark;
   logic              w_rollback;
   logic              w_complete;
   logic              w_abort;
   logic              w_ovf_set;
   logic              w_pop_try;
   logic              w_pop_do;
   logic [ADDR_W:0]   w_sp;
   logic              w_full;
   logic              w_empty;
   logic [ADDR_W-1:0] w_pop_addr;

   assign w_match    = (rx_packet[DEST_HI:DEST_LO] == node_id);
   assign w_beat_inc = r_beat + 1'b1;
   assign w_pop_addr = w_sp[ADDR_W-1:0] - 1'b1;

   always_comb begin
      w_state_next = r_state;
      w_beat_next  = r_beat;
      w_write      = 1'b0;
      w_mark       = 1'b0;
      w_rollback   = 1'b0;
      w_complete   = 1'b0;
      w_abort      = 1'b0;
      w_ovf_set    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_match) begin
               if (!w_full) begin
                  w_write = 1'b1;
                  w_mark  = 1'b1;
                  if (ONE_BEAT == LAST_BEAT) begin
                     w_complete = 1'b1;
                  end else begin
                     w_beat_next  = ONE_BEAT;
                     w_state_next = RECV;
                  end
               end else begin
                  w_ovf_set = 1'b1;
               end
            end
         end
         RECV: begin
            if (w_match && !w_full) begin
               w_write = 1'b1;
               if (w_beat_inc == LAST_BEAT) begin
                  w_complete   = 1'b1;
                  w_beat_next  = '0;
                  w_state_next = IDLE;
               end else begin
                  w_beat_next = w_beat_inc;
               end
            end else begin
               // Foreign packet or no room: discard the partial burst.
               w_ovf_set    = w_match;
               w_rollback   = 1'b1;
               w_abort      = 1'b1;
               w_beat_next  = '0;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_beat_next  = '0;
         end
      endcase
   end

   // Pops only use the port in idle cycles left free by writes.
   assign w_pop_try = r_pop_pending && (r_state == IDLE) && !w_write;
   assign w_pop_do  = w_pop_try && !w_empty;

   dp_stack_ptr #(
      .ADDR_W (ADDR_W)
   ) u_stack_ptr (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_write),
      .i_pop      (w_pop_do),
      .i_rollback (w_rollback),
      .i_mark     (w_mark),
      .o_sp       (w_sp),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_next;
         r_beat  <= w_beat_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pop_pending <= 1'b0;
         r_pop_s1      <= 1'b0;
         r_pop_s2      <= 1'b0;
         r_pop_valid   <= 1'b0;
         r_ram_we      <= 1'b0;
         r_ram_addr    <= '0;
         r_ram_wdata   <= '0;
         r_rx_complete <= 1'b0;
         r_rx_abort    <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         r_ram_we <= w_write;
         if (w_write) begin
            r_ram_addr  <= w_sp[ADDR_W-1:0];
            r_ram_wdata <= rx_packet[DATA_W-1:0];
         end else if (w_pop_do) begin
            r_ram_addr <= w_pop_addr;
         end
         // A request arriving while one is pending merges into it.
         if (w_pop_try) begin
            r_pop_pending <= 1'b0;
         end else if (gpp_pop) begin
            r_pop_pending <= 1'b1;
         end
         r_pop_s1      <= w_pop_do;
         r_pop_s2      <= r_pop_s1;
         r_pop_valid   <= r_pop_s2;
         r_rx_complete <= w_complete;
         r_rx_abort    <= w_abort;
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign ram_we       = r_ram_we;
   assign ram_addr     = r_ram_addr;
   assign ram_wdata    = r_ram_wdata;
   assign pop_valid    = r_pop_valid;
   assign rx_complete  = r_rx_complete;
   assign rx_abort     = r_rx_abort;
   assign stack_count  = w_sp;
   assign stack_empty  = w_empty;
   assign stack_full   = w_full;
   assign overflow_err = r_overflow;

endmodule

// File: tb/tb_data_plane_rx_ctrl.sv
// Directed and randomized bench for data_plane_rx_ctrl against a queue-based
// reference model of the receive stack.
module tb_data_plane_rx_ctrl;

   localparam int unsigned AW    = 3;
   localparam int unsigned BL    = 5;
   localparam int unsigned IW    = 16;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic [31:0]   rx_packet;
   logic [IW-1:0] node_id;
   logic          gpp_pop;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_wdata;
   logic          pop_valid;
   logic          rx_complete;
   logic          rx_abort;
   logic [AW:0]   stack_count;
   logic          stack_empty;
   logic          stack_full;
   logic          overflow_err;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0]   stk[$];
   int            burst_base = 0;
   int            burst_n    = 0;
   bit            pend       = 0;
   bit            ovf        = 0;
   bit            pv1        = 0;
   bit            pv2        = 0;
   bit            e_we       = 0;
   bit            e_cmp      = 0;
   bit            e_abt      = 0;
   bit            e_pv       = 0;
   logic [AW-1:0] e_addr     = '0;
   logic [15:0]   e_wdata    = '0;

   data_plane_rx_ctrl #(
      .ADDR_W    (AW),
      .BURST_LEN (BL),
      .ID_W      (IW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_packet    (rx_packet),
      .node_id      (node_id),
      .gpp_pop      (gpp_pop),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .pop_valid    (pop_valid),
      .rx_complete  (rx_complete),
      .rx_abort     (rx_abort),
      .stack_count  (stack_count),
      .stack_empty  (stack_empty),
      .stack_full   (stack_full),
      .overflow_err (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the stack is a queue of stored words; a burst remembers the
   // queue length it started from so an abort can truncate back to it.
   task automatic model_step();
      bit match;
      bit full;
      bit was_idle;
      bit wrote;
      bit pv_new;
      if (rst) begin
         stk.delete();
         burst_base = 0;
         burst_n    = 0;
         pend       = 0;
         ovf        = 0;
         pv1        = 0;
         pv2        = 0;
         e_we       = 0;
         e_cmp      = 0;
         e_abt      = 0;
         e_pv       = 0;
         e_addr     = '0;
         e_wdata    = '0;
         return;
      end
      match    = (rx_packet[31:16] == node_id);
      full     = (stk.size() == DEPTH);
      was_idle = (burst_n == 0);
      wrote    = 0;
      pv_new   = 0;
      e_cmp    = 0;
      e_abt    = 0;
      if (match && !full) begin
         if (was_idle) burst_base = stk.size();
         e_addr  = AW'(stk.size());
         e_wdata = rx_packet[15:0];
         stk.push_back(rx_packet[15:0]);
         wrote   = 1;
         burst_n = burst_n + 1;
         if (burst_n == BL) begin
            e_cmp   = 1;
            burst_n = 0;
         end
      end else if (was_idle) begin
         if (match) ovf = 1;
      end else begin
         if (match) ovf = 1;
         while (stk.size() > burst_base) void'(stk.pop_back());
         e_abt   = 1;
         burst_n = 0;
      end
      if (pend && was_idle && !wrote) begin
         pend = 0;
         if (stk.size() > 0) begin
            void'(stk.pop_back());
            e_addr = AW'(stk.size());
            pv_new = 1;
         end
      end else if (gpp_pop) begin
         pend = 1;
      end
      e_we = wrote;
      e_pv = pv2;
      pv2  = pv1;
      pv1  = pv_new;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
      chk("pop_valid", 32'(pop_valid), 32'(e_pv));
      chk("rx_complete", 32'(rx_complete), 32'(e_cmp));
      chk("rx_abort", 32'(rx_abort), 32'(e_abt));
      chk("stack_count", 32'(stack_count), 32'(stk.size()));
      chk("stack_empty", 32'(stack_empty), 32'(stk.size() == 0));
      chk("stack_full", 32'(stack_full), 32'(stk.size() == DEPTH));
      chk("overflow_err", 32'(overflow_err), 32'(ovf));
      chk("cmp_abt_excl", 32'(rx_complete & rx_abort), 32'd0);
   endtask

   task automatic cyc(input logic [31:0] pkt, input logic pop, input logic r);
      rx_packet = pkt;
      gpp_pop   = pop;
      rst       = r;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   localparam logic [31:0] IDLE_PKT = 32'h0000_0000;

   initial begin
      logic [15:0] dst;
      node_id   = 16'h0003;
      rx_packet = IDLE_PKT;
      gpp_pop   = 1'b0;
      rst       = 1'b1;
      cyc(IDLE_PKT, 1'b0, 1'b1);
      cyc(IDLE_PKT, 1'b0, 1'b1);
      chk("reset_empty", 32'(stack_empty), 32'd1);
      chk("reset_count", 32'(stack_count), 32'd0);

      // Three words then a foreign packet: discard.
      for (int i = 0; i < 3; i++) cyc({16'h0003, 16'h0021 + 16'(i)}, 1'b0, 1'b0);
      cyc({16'h0007, 16'h0099}, 1'b0, 1'b0);
      chk("abort_pulse", 32'(rx_abort), 32'd1);
      chk("abort_count", 32'(stack_count), 32'd0);
      cyc(IDLE_PKT, 1'b0, 1'b0);

      // Full burst with a pop requested mid-burst.
      for (int i = 0; i < 5; i++) begin
         cyc({16'h0003, 16'h0011 + 16'(i)}, (i == 1), 1'b0);
         chk("burst_addr", 32'(ram_addr), 32'(i));
      end
      chk("burst_complete", 32'(rx_complete), 32'd1);
      chk("burst_count", 32'(stack_count), 32'd5);
      cyc(IDLE_PKT, 1'b0, 1'b0);
      chk("pop_addr", 32'(ram_addr), 32'd4);
      chk("pop_count", 32'(stack_count), 32'd4);
      cyc(IDLE_PKT, 1'b0, 1'b0);
      cyc(IDLE_PKT, 1'b0, 1'b0);
      chk("pop_valid_lat", 32'(pop_valid), 32'd1);

      // Fill to full and overflow on the next matching word.
      cyc(IDLE_PKT, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc({16'h0003, 16'h0031 + 16'(i)}, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc({16'h0003, 16'h0041 + 16'(i)}, 1'b0, 1'b0);
      chk("full_flag", 32'(stack_full), 32'd1);
      cyc({16'h0003, 16'h0044}, 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow_err), 32'd1);
      chk("ovf_abort", 32'(rx_abort), 32'd1);
      chk("ovf_count", 32'(stack_count), 32'd5);
      for (int i = 0; i < 3; i++) cyc(IDLE_PKT, 1'b0, 1'b0);
      chk("ovf_sticky", 32'(overflow_err), 32'd1);

      // Pop on empty is dropped; then reset mid-burst.
      cyc(IDLE_PKT, 1'b0, 1'b1);
      cyc(IDLE_PKT, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(IDLE_PKT, 1'b0, 1'b0);
      chk("empty_pop_count", 32'(stack_count), 32'd0);
      cyc({16'h0003, 16'h0061}, 1'b0, 1'b0);
      cyc({16'h0003, 16'h0062}, 1'b0, 1'b0);
      cyc({16'h0003, 16'h0063}, 1'b0, 1'b1);
      chk("midrst_we", 32'(ram_we), 32'd0);
      chk("midrst_count", 32'(stack_count), 32'd0);

      // Pending pop collides with a matching word in IDLE.
      cyc(IDLE_PKT, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc({16'h0003, 16'h0051 + 16'(i)}, 1'b0, 1'b0);
         if (i == 0) chk("collide_addr", 32'(ram_addr), 32'd0);
      end
      cyc(IDLE_PKT, 1'b0, 1'b0);
      chk("collide_pop_addr", 32'(ram_addr), 32'd4);

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(63) == 0) node_id = ($urandom_range(1) == 0) ? 16'h0003 : 16'h1234;
         dst = ($urandom_range(9) < 8) ? node_id : 16'($urandom);
         cyc({dst, 16'($urandom)}, ($urandom_range(5) == 0), ($urandom_range(149) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
